// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: classifies high pulses into bits, assembles GRB pixels and
// detects the latch gap. Define WS2812_RX_FWD_EN to act as one chained LED with a dout port.
module ws2812_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int T1_THRESH_NS = 600,
  parameter int T_GLITCH_NS  = 100,
  parameter int T_MAX_NS     = 2000,
  parameter int RESET_NS     = 50000,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [7:0]        pixel_red,
  output logic [7:0]        pixel_green,
  output logic [7:0]        pixel_blue,
  output logic              pixel_valid,
  output logic              frame_done,
`ifdef WS2812_RX_FWD_EN
  output logic              dout,
`endif
  output logic              bit_err
);

  localparam int CYC_PER_US = CLK_FREQ / 1_000_000;
  localparam logic [15:0] THRESH_C = 16'(CYC_PER_US * T1_THRESH_NS / 1000);
  localparam logic [15:0] GLITCH_C = 16'(CYC_PER_US * T_GLITCH_NS / 1000);
  localparam logic [15:0] MAX_C    = 16'(CYC_PER_US * T_MAX_NS / 1000);
  localparam logic [15:0] RESET_C  = 16'(CYC_PER_US * RESET_NS / 1000);

`ifdef WS2812_RX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [2:0] ST_SYNC = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_LOW  = 3'd2;
  localparam logic [2:0] ST_HIGH = 3'd3;
  localparam logic [2:0] ST_FWD  = 3'd4;

  logic              sync1_q, sync2_q, dly_q;
  logic              rise_s, fall_s, bit_s;
  logic [2:0]        state_q, state_d;
  logic [15:0]       hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d, hi_inc_s, lo_inc_s;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d, word_s;
  logic              got_bit_q, got_bit_d, capt_q, capt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              valid_q, valid_d, done_q, done_d, err_q, err_d;

  assign rise_s   = sync2_q & ~dly_q;
  assign fall_s   = ~sync2_q & dly_q;
  assign hi_inc_s = (hi_cnt_q == 16'hFFFF) ? hi_cnt_q : hi_cnt_q + 16'd1;
  assign lo_inc_s = (lo_cnt_q == 16'hFFFF) ? lo_cnt_q : lo_cnt_q + 16'd1;
  assign bit_s    = (hi_cnt_q >= THRESH_C);
  assign word_s   = {shift_q[22:0], bit_s};

  // Next-state and output decode for the pulse classifier
  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    got_bit_d = got_bit_q;
    capt_d    = capt_q;
    addr_d    = (valid_q && !FWD_EN) ? addr_q + {{(ADDR_W-1){1'b0}}, 1'b1} : addr_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (sync2_q) begin
          lo_cnt_d = 16'd0;
        end else begin
          lo_cnt_d = lo_inc_s;
          if (lo_inc_s >= RESET_C) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            got_bit_d = 1'b0;
            capt_d    = 1'b0;
            addr_d    = '0;
          end else begin
            state_d = ST_SYNC;
          end
        end
      end
      ST_IDLE: begin
        if (rise_s) begin
          hi_cnt_d = 16'd1;
          state_d  = ST_HIGH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          hi_cnt_d = 16'd1;
          lo_cnt_d = 16'd0;
          state_d  = (capt_q && FWD_EN) ? ST_FWD : ST_HIGH;
        end else if (lo_inc_s >= RESET_C) begin
          // Latch gap: an unfinished pixel is a protocol error
          done_d    = got_bit_q;
          err_d     = (bit_cnt_q != 5'd0);
          bit_cnt_d = 5'd0;
          got_bit_d = 1'b0;
          capt_d    = 1'b0;
          addr_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          lo_cnt_d = lo_inc_s;
        end
      end
      ST_HIGH: begin
        if ((fall_s && (hi_cnt_q < GLITCH_C || hi_cnt_q > MAX_C)) ||
            (!fall_s && hi_inc_s > MAX_C)) begin
          err_d     = 1'b1;
          bit_cnt_d = 5'd0;
          capt_d    = 1'b0;
          lo_cnt_d  = 16'd0;
          state_d   = ST_SYNC;
        end else if (fall_s) begin
          shift_d   = word_s;
          got_bit_d = 1'b1;
          lo_cnt_d  = 16'd1;
          state_d   = ST_LOW;
          if (bit_cnt_q == 5'd23) begin
            valid_d   = 1'b1;
            green_d   = word_s[23:16];
            red_d     = word_s[15:8];
            blue_d    = word_s[7:0];
            bit_cnt_d = 5'd0;
            capt_d    = FWD_EN;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          hi_cnt_d = hi_inc_s;
        end
      end
      ST_FWD: begin
        // Forwarding: only the latch gap matters, pulse shapes are passed through untouched
        if (sync2_q) begin
          lo_cnt_d = 16'd0;
        end else if (lo_inc_s >= RESET_C) begin
          done_d    = got_bit_q;
          bit_cnt_d = 5'd0;
          got_bit_d = 1'b0;
          capt_d    = 1'b0;
          addr_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          lo_cnt_d = lo_inc_s;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // Synchronizer, edge register and all state/outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      dly_q     <= 1'b0;
      state_q   <= ST_SYNC;
      hi_cnt_q  <= 16'd0;
      lo_cnt_q  <= 16'd0;
      bit_cnt_q <= 5'd0;
      shift_q   <= 24'd0;
      got_bit_q <= 1'b0;
      capt_q    <= 1'b0;
      addr_q    <= '0;
      red_q     <= 8'd0;
      green_q   <= 8'd0;
      blue_q    <= 8'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= din;
      sync2_q   <= sync1_q;
      dly_q     <= sync2_q;
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      got_bit_q <= got_bit_d;
      capt_q    <= capt_d;
      addr_q    <= addr_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef WS2812_RX_FWD_EN
  logic dout_q;

  // Forwarded line: synchronizer output delayed by two cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= (state_q == ST_FWD) ? dly_q : 1'b0;
    end
  end

  assign dout = dout_q;
`endif

  assign pixel_addr  = addr_q;
  assign pixel_red   = red_q;
  assign pixel_green = green_q;
  assign pixel_blue  = blue_q;
  assign pixel_valid = valid_q;
  assign frame_done  = done_q;
  assign bit_err     = err_q;

endmodule
